// File: rtl/seq_logic_unit.sv
// Multi-cycle bitwise logic unit (AND/OR/XOR/NOR), one SLICE-bit slice per clock, LSB first.
// Optional build macro: LOGIC_ZERO_FLAG_EN adds the registered zero flag output.
module seq_logic_unit #(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
`ifdef LOGIC_ZERO_FLAG_EN
    output logic             zero,
`endif
    output logic [WIDTH-1:0] result
);

    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if (SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_params
        $error("seq_logic_unit: WIDTH must be a positive multiple of SLICE");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CW-1:0]     count;
    logic [1:0]        op_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  work;
    logic [WIDTH-1:0]  work_next;
    logic [SLICE-1:0]  a_slice;
    logic [SLICE-1:0]  b_slice;
    logic [SLICE-1:0]  slice_val;
    int unsigned       base;

    always_comb begin
        base      = 32'(count) * 32'(SLICE);
        a_slice   = a_q[base +: SLICE];
        b_slice   = b_q[base +: SLICE];
        slice_val = '0;
        case (op_q)
            2'b00:   slice_val = a_slice & b_slice;
            2'b01:   slice_val = a_slice | b_slice;
            2'b10:   slice_val = a_slice ^ b_slice;
            default: slice_val = ~(a_slice | b_slice);
        endcase
        work_next = work;
        work_next[base +: SLICE] = slice_val;
    end

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) state_next = RUN;
            end
            RUN: begin
                if (count == LAST) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef LOGIC_ZERO_FLAG_EN
    logic sticky;

    // Sticky nonzero bit accumulates every slice so zero is known on the final edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sticky <= 1'b0;
            zero   <= 1'b0;
        end else if (state == IDLE && start) begin
            sticky <= 1'b0;
        end else if (state == RUN) begin
            sticky <= sticky | (|slice_val);
            if (count == LAST) zero <= ~(sticky | (|slice_val));
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            count  <= '0;
            result <= '0;
            work   <= '0;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        op_q  <= op;
                        count <= '0;
                        work  <= '0;
                    end
                end
                RUN: begin
                    work <= work_next;
                    if (count == LAST) result <= work_next;
                    else               count  <= count + CW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_logic_unit.sv
// Directed self-checking bench for seq_logic_unit (32/4 instance plus an 8/8 single-slice instance).
module tb_seq_logic_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        ready;
    logic        done;
    logic [31:0] result;
`ifdef LOGIC_ZERO_FLAG_EN
    logic        zero;
`endif

    logic        start8;
    logic [1:0]  op8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        ready8;
    logic        done8;
    logic [7:0]  result8;
`ifdef LOGIC_ZERO_FLAG_EN
    logic        zero8;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_logic_unit #(.WIDTH(32), .SLICE(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .ready  (ready),
        .done   (done),
`ifdef LOGIC_ZERO_FLAG_EN
        .zero   (zero),
`endif
        .result (result)
    );

    seq_logic_unit #(.WIDTH(8), .SLICE(8)) dut8 (
        .clk    (clk),
        .reset  (reset),
        .start  (start8),
        .op     (op8),
        .a      (a8),
        .b      (b8),
        .ready  (ready8),
        .done   (done8),
`ifdef LOGIC_ZERO_FLAG_EN
        .zero   (zero8),
`endif
        .result (result8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Accept one op on the 32-bit unit and wait (bounded) for done; reports cycles after accept.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int cycles, output int ready_hi);
        op = o; a = x; b = y; start = 1'b1;
        tick();
        start = 1'b0; a = '1; b = '1; op = 2'b00;
        cycles = 0;
        ready_hi = 0;
        while (done !== 1'b1 && cycles < 40) begin
            if (ready !== 1'b0) ready_hi++;
            tick();
            cycles++;
        end
        if (ready !== 1'b0) ready_hi++;
    endtask

    int cyc;
    int rdy;
    int pulses;

    initial begin
        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
        tick();
        tick();
        reset = 1'b0;
        check("reset_ready",  32'(ready),  32'd1);
        check("reset_done",   32'(done),   32'd0);
        check("reset_result", result,      32'h0);
`ifdef LOGIC_ZERO_FLAG_EN
        check("reset_zero",   32'(zero),   32'd0);
`endif

        // OR: latency and ready low through RUN/DONE
        run_op(2'b01, 32'hF0F0_0000, 32'h0000_0F0F, cyc, rdy);
        check("or_latency", 32'(cyc), 32'd8);
        check("or_ready_low", 32'(rdy), 32'd0);
        check("or_result", result, 32'hF0F0_0F0F);
        tick();
        check("or_done_pulse", 32'(done), 32'd0);
        check("or_ready_back", 32'(ready), 32'd1);
        check("or_result_held", result, 32'hF0F0_0F0F);

        run_op(2'b11, 32'h0, 32'h0, cyc, rdy);
        check("nor_result", result, 32'hFFFF_FFFF);
        tick();
        run_op(2'b00, 32'hFFFF_0000, 32'h0F0F_0F0F, cyc, rdy);
        check("and_result", result, 32'h0F0F_0000);
        tick();
        run_op(2'b10, 32'hFFFF_0000, 32'h0F0F_0F0F, cyc, rdy);
        check("xor_result", result, 32'hF0F0_0F0F);
        tick();

        // start pulses during RUN (edge 2) and DONE (edge 9) must be ignored
        op = 2'b01; a = 32'hF0F0_0000; b = 32'h0000_0F0F; start = 1'b1;
        tick();
        pulses = 0;
        for (int k = 1; k <= 12; k++) begin
            if (k == 2 || k == 9) begin
                start = 1'b1; op = 2'b00; a = 32'h0; b = 32'h0;
            end else begin
                start = 1'b0;
            end
            tick();
            if (done === 1'b1) pulses++;
        end
        start = 1'b0;
        check("ignore_pulses", 32'(pulses), 32'd1);
        check("ignore_result", result, 32'hF0F0_0F0F);
        check("ignore_ready", 32'(ready), 32'd1);

        // reset on RUN cycle 3 aborts the op
        op = 2'b11; a = 32'h0; b = 32'h0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_result", result, 32'h0);
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            if (done === 1'b1) pulses++;
            tick();
        end
        check("abort_no_done", 32'(pulses), 32'd0);
        run_op(2'b00, 32'h1234_5678, 32'hFF00_FF00, cyc, rdy);
        check("after_abort_latency", 32'(cyc), 32'd8);
        check("after_abort_result", result, 32'h1200_5600);
        tick();

`ifdef LOGIC_ZERO_FLAG_EN
        run_op(2'b10, 32'h1234_5678, 32'h1234_5678, cyc, rdy);
        check("zero_result", result, 32'h0);
        check("zero_set", 32'(zero), 32'd1);
        tick();
        check("zero_held", 32'(zero), 32'd1);
        run_op(2'b10, 32'h0000_0001, 32'h0, cyc, rdy);
        check("zero_clear_result", result, 32'h0000_0001);
        check("zero_clear", 32'(zero), 32'd0);
        tick();
`endif

        // single-slice instance: done one cycle after accept
        op8 = 2'b10; a8 = 8'hA5; b8 = 8'hFF; start8 = 1'b1;
        tick();
        start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        check("n1_ready_low", 32'(ready8), 32'd0);
        check("n1_no_done_yet", 32'(done8), 32'd0);
        tick();
        check("n1_done", 32'(done8), 32'd1);
        check("n1_result", 32'(result8), 32'h5A);
        tick();
        check("n1_ready_back", 32'(ready8), 32'd1);
        check("n1_result_held", 32'(result8), 32'h5A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
